counter_limit_nch: RTL and testbench



---
 rtl/counter_limit_pkg.sv | 16 +
 rtl/counter_limit_ch.sv | 93 +++++++++
 rtl/counter_limit_nch.sv | 50 +++++
 tb/tb_counter_limit_nch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_limit_pkg.sv
// Shared mode encoding for the multi-channel limit counter.
package counter_limit_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // The reserved encoding runs as WRAP so a stray mode value still counts.
  function automatic mode_e map_mode(input logic [1:0] raw);
    return (raw == MODE_RSVD) ? MODE_WRAP : mode_e'(raw);
  endfunction

endpackage

// File: rtl/counter_limit_ch.sv
// One limit-counter channel: count register, terminal detection, one-shot
// halt, registered wrap pulse and sticky overflow.
module counter_limit_ch
  import counter_limit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             ovf_clear,
  output logic [WIDTH-1:0] q,
  output logic             at_term,
  output logic             pre_term,
  output logic             wrap_pulse,
  output logic             sticky_ovf,
  output logic             done
);

  function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] value,
                                                      input logic [WIDTH-1:0] lim);
    return (value > lim) ? lim : value;
  endfunction

  mode_e            mode_eff;
  logic             halted;
  logic             term_event;
  logic             done_next;
  logic [WIDTH-1:0] q_next;

  assign mode_eff = map_mode(mode);
  assign halted   = (mode_eff == MODE_ONESHOT) && done;

  // Up-count uses >= so a limit lowered below q is still seen as terminal.
  always_comb begin
    at_term  = up ? (q >= limit) : (q == '0);
    pre_term = 1'b0;
    if (limit != '0) begin
      pre_term = up ? (q == limit - WIDTH'(1)) : (q == WIDTH'(1));
    end
  end

  always_comb begin
    q_next     = q;
    done_next  = done;
    term_event = 1'b0;
    if (clear) begin
      q_next    = '0;
      done_next = 1'b0;
    end else if (load) begin
      q_next    = clamp_to_limit(load_value, limit);
      done_next = 1'b0;
    end else if (enable && !halted) begin
      if (at_term) begin
        case (mode_eff)
          MODE_SAT: q_next = up ? limit : '0;
          MODE_ONESHOT: begin
            done_next  = 1'b1;
            term_event = 1'b1;
          end
          default: begin
            q_next     = up ? '0 : limit;
            term_event = 1'b1;
          end
        endcase
      end else begin
        q_next = up ? q + WIDTH'(1) : q - WIDTH'(1);
      end
    end
  end

  // Register stage: all state updates on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= '0;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      q          <= q_next;
      done       <= done_next;
      wrap_pulse <= term_event;
      sticky_ovf <= term_event | (sticky_ovf & ~ovf_clear);
    end
  end

endmodule

// File: rtl/counter_limit_nch.sv
// NUM_CH independent limit counters sharing one clock and reset; the top only
// slices the packed per-channel buses.
module counter_limit_nch
  import counter_limit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_value,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  input  logic [NUM_CH*2-1:0]     mode,
  input  logic [NUM_CH-1:0]       ovf_clear,
  output logic [NUM_CH*WIDTH-1:0] Q,
  output logic [NUM_CH-1:0]       at_term,
  output logic [NUM_CH-1:0]       pre_term,
  output logic [NUM_CH-1:0]       wrap_pulse,
  output logic [NUM_CH-1:0]       sticky_ovf,
  output logic [NUM_CH-1:0]       done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_limit_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable[i]),
      .clear     (clear[i]),
      .load      (load[i]),
      .load_value(load_value[i*WIDTH +: WIDTH]),
      .up        (up[i]),
      .limit     (limit[i*WIDTH +: WIDTH]),
      .mode      (mode[2*i +: 2]),
      .ovf_clear (ovf_clear[i]),
      .q         (Q[i*WIDTH +: WIDTH]),
      .at_term   (at_term[i]),
      .pre_term  (pre_term[i]),
      .wrap_pulse(wrap_pulse[i]),
      .sticky_ovf(sticky_ovf[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_counter_limit_nch.sv
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_counter_limit_nch;
  localparam int W = 8;
  localparam int N = 2;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]   enable, clear, load, up, ovf_clear;
  logic [N*W-1:0] load_value, limit;
  logic [2*N-1:0] mode;
  logic [N*W-1:0] Q;
  logic [N-1:0]   at_term, pre_term, wrap_pulse, sticky_ovf, done;

  int vectors = 0;
  int miscompares = 0;
  int mq[N];
  bit mdone[N], mwp[N], mso[N];

  counter_limit_nch #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up(up), .limit(limit), .mode(mode),
    .ovf_clear(ovf_clear), .Q(Q), .at_term(at_term), .pre_term(pre_term),
    .wrap_pulse(wrap_pulse), .sticky_ovf(sticky_ovf), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int qv(int c);  return int'(Q[c*W +: W]); endfunction
  function automatic int lim(int c); return int'(limit[c*W +: W]); endfunction
  function automatic int lv(int c);  return int'(load_value[c*W +: W]); endfunction

  function automatic bit exp_at(int c);
    return up[c] ? (mq[c] >= lim(c)) : (mq[c] == 0);
  endfunction

  function automatic bit exp_pre(int c);
    if (lim(c) == 0) return 1'b0;
    return up[c] ? (mq[c] == lim(c) - 1) : (mq[c] == 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mq[c] = 0; mdone[c] = 0; mwp[c] = 0; mso[c] = 0;
    end
  endtask

  // Reference behaviour of one clock edge, from the per-channel rules.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      int q;
      int l;
      int md;
      bit term;
      bit evt;
      q = mq[c]; l = lim(c); md = int'(mode[2*c +: 2]); term = exp_at(c); evt = 0;
      if (md == 3) md = 0;
      if (clear[c]) begin
        q = 0; mdone[c] = 0;
      end else if (load[c]) begin
        q = (lv(c) > l) ? l : lv(c); mdone[c] = 0;
      end else if (enable[c] && !(md == 2 && mdone[c])) begin
        if (!term) q = up[c] ? (q + 1) % M : (q + M - 1) % M;
        else if (md == 0) begin q = up[c] ? 0 : l; evt = 1; end
        else if (md == 1) q = up[c] ? l : 0;
        else begin mdone[c] = 1; evt = 1; end
      end
      mq[c] = q;
      mwp[c] = evt;
      mso[c] = evt | (mso[c] & !ovf_clear[c]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ch(input int c, input bit en, input bit u, input logic [1:0] md, input int l);
    enable[c] = en;
    up[c] = u;
    mode[2*c +: 2] = md;
    limit[c*W +: W] = W'(l);
  endtask

  task automatic test_reset();
    enable = '0; clear = '0; load = '0; up = '1; ovf_clear = '0;
    load_value = '0; mode = '0; limit = {8'd4, 8'd4};
    #1 rst = 1'b1;
    #2;
    vectors++; if (Q !== '0) begin miscompares++; $display("FAIL reset_q got %h want 0", Q); end
    vectors++; if (wrap_pulse !== '0 || sticky_ovf !== '0 || done !== '0) begin
      miscompares++; $display("FAIL reset_flags got wp=%b so=%b dn=%b want 0", wrap_pulse, sticky_ovf, done); end
    vectors++; if (at_term !== '0 || pre_term !== '0) begin
      miscompares++; $display("FAIL reset_term got at=%b pre=%b want 0", at_term, pre_term); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_q[6] = '{1, 2, 3, 4, 0, 1};
    set_ch(0, 1, 1, 2'b00, 4);
    for (int i = 0; i < 6; i++) begin
      cyc();
      vectors++; if (qv(0) !== exp_q[i]) begin miscompares++; $display("FAIL wrap_q[%0d] got %0d want %0d", i, qv(0), exp_q[i]); end
      vectors++; if (pre_term[0] !== (exp_q[i] == 3)) begin miscompares++; $display("FAIL wrap_pre[%0d] got %b want %b", i, pre_term[0], exp_q[i] == 3); end
      vectors++; if (at_term[0] !== (exp_q[i] == 4)) begin miscompares++; $display("FAIL wrap_at[%0d] got %b want %b", i, at_term[0], exp_q[i] == 4); end
      vectors++; if (wrap_pulse[0] !== (i == 4)) begin miscompares++; $display("FAIL wrap_wp[%0d] got %b want %b", i, wrap_pulse[0], i == 4); end
      vectors++; if (sticky_ovf[0] !== (i >= 4)) begin miscompares++; $display("FAIL wrap_so[%0d] got %b want %b", i, sticky_ovf[0], i >= 4); end
    end
    enable[0] = 1'b0; ovf_clear[0] = 1'b1;
    cyc();
    ovf_clear[0] = 1'b0;
    vectors++; if (sticky_ovf[0] !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf_clear got %b want 0", sticky_ovf[0]); end
  endtask

  task automatic test_saturate_down();
    int e;
    enable[0] = 1'b1;
    set_ch(1, 0, 0, 2'b01, 10);
    load[1] = 1'b1; load_value[W +: W] = 8'd3;
    cyc();
    load[1] = 1'b0;
    vectors++; if (qv(1) !== 3) begin miscompares++; $display("FAIL sat_load got %0d want 3", qv(1)); end
    enable[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      e = (2 - i > 0) ? 2 - i : 0;
      vectors++; if (qv(1) !== e) begin miscompares++; $display("FAIL sat_q[%0d] got %0d want %0d", i, qv(1), e); end
      vectors++; if (wrap_pulse[1] !== 1'b0 || sticky_ovf[1] !== 1'b0) begin
        miscompares++; $display("FAIL sat_flags[%0d] got wp=%b so=%b want 0", i, wrap_pulse[1], sticky_ovf[1]); end
      vectors++; if (qv(0) !== mq[0]) begin miscompares++; $display("FAIL sat_ch0_q[%0d] got %0d want %0d", i, qv(0), mq[0]); end
    end
    enable = '0;
  endtask

  task automatic test_oneshot();
    int exp_q[4]  = '{1, 2, 2, 2};
    bit exp_dn[4] = '{0, 0, 1, 1};
    bit exp_wp[4] = '{0, 0, 1, 0};
    set_ch(0, 0, 1, 2'b10, 2);
    clear[0] = 1'b1;
    cyc();
    clear[0] = 1'b0;
    vectors++; if (qv(0) !== 0 || done[0] !== 1'b0) begin miscompares++; $display("FAIL os_clear got q=%0d dn=%b want 0 0", qv(0), done[0]); end
    enable[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vectors++; if (qv(0) !== exp_q[i]) begin miscompares++; $display("FAIL os_q[%0d] got %0d want %0d", i, qv(0), exp_q[i]); end
      vectors++; if (done[0] !== exp_dn[i]) begin miscompares++; $display("FAIL os_done[%0d] got %b want %b", i, done[0], exp_dn[i]); end
      vectors++; if (wrap_pulse[0] !== exp_wp[i]) begin miscompares++; $display("FAIL os_wp[%0d] got %b want %b", i, wrap_pulse[0], exp_wp[i]); end
    end
    load[0] = 1'b1; load_value[0 +: W] = 8'd0;
    cyc();
    load[0] = 1'b0;
    vectors++; if (qv(0) !== 0 || done[0] !== 1'b0) begin miscompares++; $display("FAIL os_reload got q=%0d dn=%b want 0 0", qv(0), done[0]); end
    cyc();
    vectors++; if (qv(0) !== 1) begin miscompares++; $display("FAIL os_resume got %0d want 1", qv(0)); end
    enable[0] = 1'b0;
  endtask

  task automatic test_clear_load();
    set_ch(0, 1, 1, 2'b00, 10);
    clear[0] = 1'b1; load[0] = 1'b1; load_value[0 +: W] = 8'd5; ovf_clear[0] = 1'b1;
    cyc();
    clear[0] = 1'b0;
    vectors++; if (qv(0) !== 0) begin miscompares++; $display("FAIL clr_over_load got %0d want 0", qv(0)); end
    load_value[0 +: W] = 8'd200;
    cyc();
    load[0] = 1'b0;
    vectors++; if (qv(0) !== 10) begin miscompares++; $display("FAIL load_clamp got %0d want 10", qv(0)); end
    vectors++; if (sticky_ovf[0] !== 1'b0) begin miscompares++; $display("FAIL pre_event_so got %b want 0", sticky_ovf[0]); end
    cyc();
    ovf_clear[0] = 1'b0;
    vectors++; if (sticky_ovf[0] !== 1'b1 || wrap_pulse[0] !== 1'b1) begin
      miscompares++; $display("FAIL ovf_set_wins got so=%b wp=%b want 1 1", sticky_ovf[0], wrap_pulse[0]); end
    vectors++; if (qv(0) !== 0) begin miscompares++; $display("FAIL clr_load_wrap got %0d want 0", qv(0)); end
    enable[0] = 1'b0;
  endtask

  task automatic test_limit_lower();
    set_ch(0, 0, 1, 2'b00, 9);
    load[0] = 1'b1; load_value[0 +: W] = 8'd6;
    cyc();
    load[0] = 1'b0;
    vectors++; if (qv(0) !== 6 || at_term[0] !== 1'b0) begin miscompares++; $display("FAIL lower_setup got q=%0d at=%b want 6 0", qv(0), at_term[0]); end
    limit[0 +: W] = 8'd3;
    #1;
    vectors++; if (at_term[0] !== 1'b1 || pre_term[0] !== 1'b0) begin
      miscompares++; $display("FAIL lower_term got at=%b pre=%b want 1 0", at_term[0], pre_term[0]); end
    enable[0] = 1'b1;
    cyc();
    vectors++; if (qv(0) !== 0 || wrap_pulse[0] !== 1'b1) begin
      miscompares++; $display("FAIL lower_wrap got q=%0d wp=%b want 0 1", qv(0), wrap_pulse[0]); end
    enable[0] = 1'b0;
  endtask

  task automatic test_async_reset();
    set_ch(0, 0, 1, 2'b00, 9);
    load[0] = 1'b1; load_value[0 +: W] = 8'd3;
    set_ch(1, 1, 1, 2'b10, 0);
    cyc();
    load[0] = 1'b0;
    vectors++; if (qv(0) !== 3 || done[1] !== 1'b1 || wrap_pulse[1] !== 1'b1 || sticky_ovf !== 2'b11) begin
      miscompares++; $display("FAIL arst_setup got q0=%0d dn1=%b wp1=%b so=%b want 3 1 1 11", qv(0), done[1], wrap_pulse[1], sticky_ovf); end
    enable[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++; if (Q !== '0 || done !== '0 || sticky_ovf !== '0 || wrap_pulse !== '0) begin
      miscompares++; $display("FAIL arst_clear got q=%h dn=%b so=%b wp=%b want 0", Q, done, sticky_ovf, wrap_pulse); end
    vectors++; if (at_term !== 2'b10) begin miscompares++; $display("FAIL arst_at got %b want 10", at_term); end
    model_reset();
    #2 rst = 1'b0;
    enable[1] = 1'b0;
    cyc();
    vectors++; if (qv(0) !== 1 || wrap_pulse[0] !== 1'b0) begin
      miscompares++; $display("FAIL arst_resume got q=%0d wp=%b want 1 0", qv(0), wrap_pulse[0]); end
    enable = '0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      for (int c = 0; c < N; c++) begin
        enable[c]    = ($urandom_range(0, 9) != 0);
        clear[c]     = ($urandom_range(0, 29) == 0);
        load[c]      = ($urandom_range(0, 19) == 0);
        ovf_clear[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 9) == 0) up[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 11) == 0)
          limit[c*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
        load_value[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
      end
      #1;
      for (int c = 0; c < N; c++) begin
        vectors++; if (at_term[c] !== exp_at(c) || pre_term[c] !== exp_pre(c)) begin
          miscompares++; $display("FAIL rnd_comb[%0d] ch%0d got at=%b pre=%b want %b %b", it, c, at_term[c], pre_term[c], exp_at(c), exp_pre(c)); end
      end
      cyc();
      for (int c = 0; c < N; c++) begin
        vectors++; if (qv(c) !== mq[c]) begin miscompares++; $display("FAIL rnd_q[%0d] ch%0d got %0d want %0d", it, c, qv(c), mq[c]); end
        vectors++; if (wrap_pulse[c] !== mwp[c] || sticky_ovf[c] !== mso[c] || done[c] !== mdone[c]) begin
          miscompares++; $display("FAIL rnd_flags[%0d] ch%0d got wp=%b so=%b dn=%b want %b %b %b", it, c,
                                  wrap_pulse[c], sticky_ovf[c], done[c], mwp[c], mso[c], mdone[c]); end
        vectors++; if (at_term[c] !== exp_at(c) || pre_term[c] !== exp_pre(c)) begin
          miscompares++; $display("FAIL rnd_term[%0d] ch%0d got at=%b pre=%b want %b %b", it, c, at_term[c], pre_term[c], exp_at(c), exp_pre(c)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate_down();
    test_oneshot();
    test_clear_load();
    test_limit_lower();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
